// File: rtl/carrier_sequencer.sv
// rtl/carrier_sequencer.sv - burst sequencer for the carrier modulator (preamble/data/guard), optional SEQ_PARITY_EN
module carrier_sequencer #(
    parameter int CLK_FREQ         = 100000000,
    parameter int SYMBOL_RATE      = 10000,
    parameter int PREAMBLE_SYMBOLS = 8,
    parameter int GUARD_SYMBOLS    = 2
) (
    input  logic       reset_trigger,
    input  logic       CLK,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       car_enable,
    output logic [1:0] car_select,
    output logic       symbol_strobe,
    output logic       busy
);

    localparam int P       = CLK_FREQ / SYMBOL_RATE;
    localparam int CNT_W   = $clog2(P);
    localparam int IDX_MAX = (PREAMBLE_SYMBOLS > GUARD_SYMBOLS)
                           ? ((PREAMBLE_SYMBOLS > 5) ? PREAMBLE_SYMBOLS : 5)
                           : ((GUARD_SYMBOLS > 5) ? GUARD_SYMBOLS : 5);
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
`ifdef SEQ_PARITY_EN
    localparam int DATA_SYMS = 5;
`else
    localparam int DATA_SYMS = 4;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_SYMBOLS - 1);
    localparam logic [IDX_W-1:0] GRD_LAST  = IDX_W'(GUARD_SYMBOLS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_SYMS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GUARD} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       byte_q;
    logic             car_enable_q;
    logic [1:0]       car_select_q;

    logic             strobe;
    logic             accept;
    logic [IDX_W-1:0] idx_d;
    logic [1:0]       data_sel_d;

    // Dibit for data symbol i of a byte, MSB first; index 4 is the parity symbol when enabled.
    function automatic logic [1:0] data_symbol(input logic [7:0] b, input int i);
        logic [1:0] s;
        case (i)
            0:       s = b[7:6];
            1:       s = b[5:4];
            2:       s = b[3:2];
            3:       s = b[1:0];
`ifdef SEQ_PARITY_EN
            4:       s = {^b[7:4], ^b[3:0]};
`endif
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    assign strobe     = (state_q != IDLE) && (count_q == CNT_LAST);
    // Back-to-back window: only the strobe cycle of the final data symbol of a byte.
    assign in_ready   = !reset_trigger &&
                        ((state_q == IDLE) ||
                         ((state_q == DATA) && (idx_q == DATA_LAST) && strobe));
    assign accept     = in_valid && in_ready;
    assign idx_d      = idx_q + 1'b1;
    assign data_sel_d = data_symbol(byte_q, int'(idx_d));

    // Sequencer FSM: symbol timer, symbol index, byte register and registered carrier controls.
    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            byte_q       <= '0;
            car_enable_q <= 1'b0;
            car_select_q <= 2'b00;
        end else if (state_q == IDLE) begin
            count_q <= '0;
            if (accept) begin
                byte_q       <= in_data;
                state_q      <= PREAMBLE;
                idx_q        <= '0;
                car_enable_q <= 1'b1;
                car_select_q <= 2'b00;
            end
        end else begin
            count_q <= strobe ? '0 : count_q + 1'b1;
            if (strobe) begin
                case (state_q)
                    PREAMBLE: begin
                        if (idx_q == PRE_LAST) begin
                            state_q      <= DATA;
                            idx_q        <= '0;
                            car_select_q <= byte_q[7:6];
                        end else begin
                            idx_q        <= idx_d;
                            car_select_q <= ~car_select_q;
                        end
                    end
                    DATA: begin
                        if (idx_q != DATA_LAST) begin
                            idx_q        <= idx_d;
                            car_select_q <= data_sel_d;
                        end else if (accept) begin
                            byte_q       <= in_data;
                            idx_q        <= '0;
                            car_select_q <= in_data[7:6];
                        end else begin
                            state_q      <= GUARD;
                            idx_q        <= '0;
                            car_enable_q <= 1'b0;
                            car_select_q <= 2'b00;
                        end
                    end
                    GUARD: begin
                        if (idx_q == GRD_LAST) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign car_enable    = car_enable_q;
    assign car_select    = car_select_q;
    assign symbol_strobe = strobe;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_carrier_sequencer.sv
// tb/tb_carrier_sequencer.sv - randomized self-checking bench for carrier_sequencer
module tb_carrier_sequencer;

    localparam int P     = 10;
    localparam int PRE   = 4;
    localparam int GUARD = 2;
`ifdef SEQ_PARITY_EN
    localparam int DPB = 5;
`else
    localparam int DPB = 4;
`endif

    logic       CLK = 1'b0;
    logic       reset_trigger;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       car_enable;
    logic [1:0] car_select;
    logic       symbol_strobe;
    logic       busy;
    logic [5:0] obs;

    int total = 0;
    int bad   = 0;

    logic [7:0] bq [4];
    bit         pending = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    carrier_sequencer #(
        .CLK_FREQ        (100),
        .SYMBOL_RATE     (10),
        .PREAMBLE_SYMBOLS(PRE),
        .GUARD_SYMBOLS   (GUARD)
    ) dut (
        .reset_trigger(reset_trigger),
        .CLK          (CLK),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .car_enable   (car_enable),
        .car_select   (car_select),
        .symbol_strobe(symbol_strobe),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    assign obs = {car_enable, car_select, symbol_strobe, busy, in_ready};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {enable, select, strobe, busy, ready} for cycle k after the opening handshake of an n-byte burst.
    function automatic logic [5:0] model(input int k, input int n);
        int         sym, ph, d, di;
        logic       en, stb, rdy;
        logic [1:0] sel;
        logic [7:0] b;
        sym = k / P;
        ph  = k % P;
        d   = sym - PRE;
        stb = (ph == P - 1);
        en  = 1'b0;
        sel = 2'b00;
        rdy = 1'b0;
        if (sym < PRE) begin
            en  = 1'b1;
            sel = (sym % 2 == 1) ? 2'b11 : 2'b00;
        end else if (d < DPB * n) begin
            b   = bq[d / DPB];
            di  = d % DPB;
            en  = 1'b1;
            sel = (di < 4) ? 2'(b >> (6 - 2 * di)) : {^b[7:4], ^b[3:0]};
            rdy = stb && (di == DPB - 1);
        end
        return {en, sel, stb, 1'b1, rdy};
    endfunction

    // b0/b1 < 0 pick random bytes; abort_at >= 0 pulses reset at that burst cycle.
    task automatic run_burst(input int n, input int abort_at, input int b0, input int b1);
        int         len, nxt, gstart, strobes, lo, hi;
        int         start [4];
        bit         gpre;
        logic [7:0] nb;
        logic [5:0] exp;
        len = (PRE + DPB * n + GUARD) * P;
        bq[0] = pending ? pend_byte : ((b0 >= 0) ? 8'(b0) : 8'($urandom));
        for (int j = 1; j < n; j++) begin
            bq[j] = (j == 1 && b1 >= 0) ? 8'(b1) : 8'($urandom);
            lo = (j == 1) ? 0 : (PRE + DPB * (j - 1)) * P;
            hi = (PRE + DPB * j) * P - 1;
            start[j] = int'($urandom_range(hi, lo));
        end
        gpre   = ($urandom_range(1, 0) == 1) && (abort_at < 0);
        gstart = int'($urandom_range(len - 1, (PRE + DPB * n) * P));
        nb     = 8'($urandom);
        if (!pending) begin
            in_valid = 1'b0;
            repeat ($urandom_range(3, 0)) begin
                @(negedge CLK);
                chk("idle", obs, 6'b000001);
                @(posedge CLK); #1;
            end
            in_valid = 1'b1;
            in_data  = bq[0];
        end
        @(negedge CLK);
        chk("accept", obs, 6'b000001);
        @(posedge CLK); #1;
        nxt     = 1;
        pending = 1'b0;
        strobes = 0;
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                in_valid = 1'b0;
                #2 reset_trigger = 1'b1;
                #1 chk("reset_abort", obs, 6'b000000);
                @(negedge CLK);
                chk("reset_hold", obs, 6'b000000);
                @(posedge CLK); #1;
                reset_trigger = 1'b0;
                @(negedge CLK);
                chk("after_reset", obs, 6'b000001);
                @(posedge CLK); #1;
                return;
            end
            if (nxt < n && k >= start[nxt]) begin
                in_valid = 1'b1;
                in_data  = bq[nxt];
            end else if (nxt == n && gpre && k >= gstart) begin
                in_valid = 1'b1;
                in_data  = nb;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            @(negedge CLK);
            exp = model(k, n);
            chk($sformatf("n%0d_b%0h_cyc%0d", n, bq[0], k), obs, exp);
            if (symbol_strobe) strobes++;
            if (exp[0] && in_valid) nxt++;
            @(posedge CLK); #1;
        end
        chk("strobe_count", strobes, PRE + DPB * n + GUARD);
        pending   = gpre;
        pend_byte = nb;
        if (!gpre) in_valid = 1'b0;
    endtask

    initial begin
        reset_trigger = 1'b1;
        in_valid      = 1'b1;
        in_data       = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_state", obs, 6'b000000);
        @(posedge CLK); #1;
        in_valid      = 1'b0;
        reset_trigger = 1'b0;

        run_burst(1, -1, 'hB4, -1);
        run_burst(2, -1, 'hB4, 'h1E);
        for (int i = 0; i < 25; i++)
            run_burst(int'($urandom_range(3, 1)), -1, -1, -1);
        run_burst(1, 55, 'hB4, -1);
        run_burst(1, -1, -1, -1);
        run_burst(3, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
